// File: rtl/psum_accum_sfu_pkg.sv
// Shared definitions for the partial-sum accumulator / special-function stage.
// Default geometry, lane saturation limits and the controller state encoding.
package psum_accum_sfu_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int NIJ     = 16;
  localparam int KIJ     = 9;

  localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psum_accum_sfu_sat_add_lane.sv
// One lane of the accumulator datapath: signed saturating add, with an optional
// ReLU clamp on the result used when draining.
module sat_add_lane
  import psum_accum_sfu_pkg::*;
#(
  parameter int                     bw      = PSUM_BW,
  parameter logic signed [bw-1:0]   sat_max = PSUM_MAX,
  parameter logic signed [bw-1:0]   sat_min = PSUM_MIN
) (
  input  logic signed [bw-1:0] a,
  input  logic signed [bw-1:0] b,
  input  logic                 relu,
  output logic signed [bw-1:0] y
);

  logic signed [bw:0]   wide;
  logic signed [bw-1:0] sat;

  // One guard bit is enough: overflow shows as the top two bits disagreeing.
  always_comb begin
    wide = {a[bw-1], a} + {b[bw-1], b};
    if (wide[bw] != wide[bw-1]) begin
      sat = wide[bw] ? sat_min : sat_max;
    end else begin
      sat = wide[bw-1:0];
    end
    y = (relu && sat[bw-1]) ? '0 : sat;
  end

endmodule

// File: rtl/psum_accum_sfu.sv
// Accumulates column-parallel partial sums from the ofifo across all kernel positions,
// then drains each output position (optionally ReLU'd) over a valid/ready stream.
module psum_accum_sfu
  import psum_accum_sfu_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int nij     = NIJ,
  parameter int kij     = KIJ,
  parameter int nij_w   = $clog2(nij)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_output,
  output logic                     ofifo_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [nij_w-1:0]         out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int kij_w = (kij > 1) ? $clog2(kij) : 1;
  localparam logic [nij_w-1:0] nij_last = nij_w'(nij - 1);
  localparam logic [kij_w-1:0] kij_last = kij_w'(kij - 1);
  localparam logic signed [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  state_t state, state_next;

  logic [nij_w-1:0]       nij_cnt;
  logic [kij_w-1:0]       kij_cnt;
  logic                   relu_q;
  logic [nij_w-1:0]       rd_idx;
  logic                   accum_last;
  logic                   drain_load;
  logic                   drain_last;
  logic                   lane_relu;
  logic [col*psum_bw-1:0] lane_a;
  logic [col*psum_bw-1:0] lane_b;
  logic [col*psum_bw-1:0] lane_y;
  logic [col*psum_bw-1:0] acc_buf [nij];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rd_idx selects the single buffer word the lane adders see: the position being
  // accumulated, or in DRAIN the word that loads into the output register next.
  always_comb begin
    state_next = state;
    ofifo_rd   = 1'b0;
    accum_last = 1'b0;
    drain_load = 1'b0;
    drain_last = 1'b0;
    rd_idx     = nij_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        ofifo_rd   = ofifo_valid;
        accum_last = ofifo_valid && (nij_cnt == nij_last) && (kij_cnt == kij_last);
        if (accum_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        drain_load = !out_valid || (out_ready && (out_addr != nij_last));
        drain_last = out_valid && out_ready && (out_addr == nij_last);
        rd_idx     = out_valid ? out_addr + 1'b1 : out_addr;
        if (drain_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The first kernel pass adds to zero, so a fresh job overwrites stale contents.
  always_comb begin
    lane_a = acc_buf[rd_idx];
    lane_b = '0;
    if (state == ACCUM) begin
      lane_b = ofifo_output;
      if (kij_cnt == '0) begin
        lane_a = '0;
      end
    end
  end

  assign lane_relu = (state == DRAIN) && relu_q;
  assign busy      = (state != IDLE);

  for (genvar c = 0; c < col; c++) begin : g_lane
    sat_add_lane #(
      .bw      (psum_bw),
      .sat_max (lane_max),
      .sat_min (lane_min)
    ) u_lane (
      .a    (lane_a[c*psum_bw +: psum_bw]),
      .b    (lane_b[c*psum_bw +: psum_bw]),
      .relu (lane_relu),
      .y    (lane_y[c*psum_bw +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (ofifo_rd) begin
      acc_buf[nij_cnt] <= lane_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nij_cnt   <= '0;
      kij_cnt   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nij_cnt <= '0;
            kij_cnt <= '0;
            relu_q  <= relu_en;
          end
        end
        ACCUM: begin
          if (ofifo_rd) begin
            if (nij_cnt == nij_last) begin
              nij_cnt <= '0;
              kij_cnt <= kij_cnt + 1'b1;
            end else begin
              nij_cnt <= nij_cnt + 1'b1;
            end
            if (accum_last) begin
              out_addr <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_load) begin
            out_valid <= 1'b1;
            out_addr  <= rd_idx;
            out_data  <= lane_y;
          end else if (drain_last) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Randomised scoreboard bench for psum_accum_sfu: expected drains are computed from
// the raw pop stream with plain saturating arithmetic and checked by a separate monitor.
module tb_psum_accum_sfu;

  localparam int COL      = 8;
  localparam int BW       = 16;
  localparam int NIJ      = 16;
  localparam int KIJ      = 9;
  localparam int NW       = 4;
  localparam int POPS     = KIJ * NIJ;
  localparam int LANE_MAX = 32767;
  localparam int LANE_MIN = -32768;

  typedef struct {
    logic [NW-1:0]     addr;
    logic [COL*BW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              relu_en = 1'b0;
  logic              ofifo_valid = 1'b0;
  logic [COL*BW-1:0] ofifo_output = '0;
  logic              ofifo_rd;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [COL*BW-1:0] out_data;
  logic [NW-1:0]     out_addr;
  logic              busy;
  logic              done;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;

  psum_accum_sfu dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .relu_en      (relu_en),
    .ofifo_valid  (ofifo_valid),
    .ofifo_output (ofifo_output),
    .ofifo_rd     (ofifo_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [COL*BW-1:0] act,
                              input logic [COL*BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > LANE_MAX) return LANE_MAX;
    if (v < LANE_MIN) return LANE_MIN;
    return v;
  endfunction

  function automatic int lane_val(input int pattern, input int c);
    int v;
    case (pattern)
      0: v = 1;
      1: v = -3;
      2: v = (c == 0) ? 28672 : (c == 1) ? -28672 : int'($urandom_range(0, 2000)) - 1000;
      3: v = 2;
      default: begin
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 65535)) - 32768;
        else v = int'($urandom_range(0, 6000)) - 3000;
      end
    endcase
    return v;
  endfunction

  // Downstream sink: always ready, a 3-cycle stall at address 5, or random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (out_valid && out_addr == 4'd5 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks stalls hold steady.
  initial begin
    bit                held;
    logic [NW-1:0]     ha;
    logic [COL*BW-1:0] hd;
    exp_t              e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check_output("hold_valid", out_valid, 1);
          check_output("hold_addr", out_addr, ha);
          check_output("hold_data", out_data, hd);
        end
        held = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            check_output("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check_output("out_addr", out_addr, e.addr);
              check_output("out_data", out_data, e.data);
            end
          end else begin
            held = 1'b1;
            ha   = out_addr;
            hd   = out_data;
          end
        end
      end
    end
  end

  // One job: vmode 0 = valid always, 1 = toggling, 2 = random; abort_after >= 0 resets mid-job.
  task automatic apply_stimulus(input logic relu, input int pattern, input int vmode,
                                input int rmode, input int abort_after, input bit poke_start);
    int                vals[POPS][COL];
    logic [COL*BW-1:0] words[POPS];
    int                idx, cyc, s;
    bit                popped, got_done;
    exp_t              e;

    for (int p = 0; p < POPS; p++) begin
      for (int c = 0; c < COL; c++) begin
        vals[p][c] = lane_val(pattern, c);
        words[p][c*BW +: BW] = 16'(vals[p][c]);
      end
    end
    if (abort_after < 0) begin
      for (int n = 0; n < NIJ; n++) begin
        e.addr = NW'(n);
        e.data = '0;
        for (int c = 0; c < COL; c++) begin
          s = 0;
          for (int k = 0; k < KIJ; k++) s = sat16(s + vals[k*NIJ + n][c]);
          if (relu && s < 0) s = 0;
          e.data[c*BW +: BW] = 16'(s);
        end
        sb.push_back(e);
      end
    end

    ready_mode = rmode;
    stall_cnt  = 0;
    @(posedge clk);
    #1;
    start        = 1'b1;
    relu_en      = relu;
    ofifo_valid  = 1'b1;
    ofifo_output = words[0];
    @(negedge clk);
    check_output("idle_no_pop", ofifo_rd, 0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    relu_en = 1'($urandom_range(0, 1));

    idx = 0;
    cyc = 0;
    while (idx < POPS && cyc < 4000) begin
      case (vmode)
        0: ofifo_valid = 1'b1;
        1: ofifo_valid = (cyc % 2 == 0);
        default: ofifo_valid = 1'($urandom_range(0, 1));
      endcase
      ofifo_output = words[idx];
      start = poke_start && (idx == 70);
      @(negedge clk);
      if (cyc == 0) check_output("busy_after_start", busy, 1);
      check_output("rd_mirror", ofifo_rd, ofifo_valid);
      popped = ofifo_rd;
      @(posedge clk);
      #1;
      if (popped) idx++;
      cyc++;
      if (abort_after >= 0 && idx == abort_after) break;
    end
    start = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b0;
      @(negedge clk);
      check_output("abort_rd", ofifo_rd, 0);
      check_output("abort_valid", out_valid, 0);
      check_output("abort_data", out_data, 0);
      check_output("abort_addr", out_addr, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check_output("no_done_after_abort", done, 0);
        check_output("idle_after_abort", ofifo_rd, 0);
      end
      ofifo_valid = 1'b0;
      return;
    end

    check_output("all_pops", idx, POPS);
    if (vmode == 0) check_output("back_to_back", cyc, POPS);

    ofifo_valid  = 1'b1;
    ofifo_output = {4{$urandom()}};
    got_done = 1'b0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      check_output("drain_no_pop", ofifo_rd, 0);
      if (done) got_done = 1'b1;
      else check_output("busy_in_drain", busy, 1);
    end
    check_output("done_seen", got_done, 1);
    check_output("busy_at_done", busy, 0);
    @(negedge clk);
    check_output("done_one_cycle", done, 0);
    check_output("sb_drained", sb.size(), 0);
    sb.delete();
    ofifo_valid = 1'b0;
  endtask

  initial begin
    #3 reset = 1'b0;
    @(negedge clk);
    check_output("reset_rd", ofifo_rd, 0);
    check_output("reset_valid", out_valid, 0);
    check_output("reset_data", out_data, 0);
    check_output("reset_addr", out_addr, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    apply_stimulus(1'b0, 0, 0, 0, -1, 1'b0);
    apply_stimulus(1'b1, 1, 0, 0, -1, 1'b0);
    apply_stimulus(1'b0, 1, 0, 0, -1, 1'b0);
    apply_stimulus(1'b0, 2, 0, 0, -1, 1'b0);
    apply_stimulus(1'b0, 0, 1, 1, -1, 1'b0);
    apply_stimulus(1'b0, 4, 2, 2, -1, 1'b1);
    apply_stimulus(1'b0, 4, 0, 0, 50, 1'b0);
    apply_stimulus(1'b0, 3, 0, 0, -1, 1'b0);
    apply_stimulus(1'b1, 4, 2, 2, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
